mem_bus_decoder: RTL and testbench
==================================

MEM_BUS_DECODER -- requirements
Module: mem_bus_decoder

Interface
REQ-001 SHALL have parameter NR_SLAVES, default 4, number of downstream slave ports (1..8).
REQ-002 SHALL have parameter MAX_OUTSTANDING, default 4, maximum accepted reads awaiting response (power of 2, 2..16).
REQ-003 SHALL have parameter SLAVE_BASE, default {32'hf0000000,32'h00010000,32'h00002000,32'h00000000}, flattened 32-bit base per slave, slave 0 in LSBs.
REQ-004 SHALL have parameter SLAVE_MASK, default {32'hffff0000,32'hffff0000,32'hffffe000,32'hffffe000}, flattened 32-bit decode mask per slave.
REQ-005 clk  input  1  single clock, all logic rising-edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 mem_cmd_valid/mem_cmd_wr/mem_cmd_instr  input  1 each  CPU command valid, write, instruction fetch.
REQ-008 mem_cmd_addr/mem_cmd_wdata  input  32 each  CPU address, write data; mem_cmd_be  input  4  byte enables.
REQ-009 mem_cmd_ready  output  1  command accepted this cycle.
REQ-010 mem_rsp_ready  output  1  read data valid; mem_rsp_rdata  output  32  read data.
REQ-011 s_cmd_valid  output  NR_SLAVES  per-slave command valid; s_cmd_ready  input  NR_SLAVES  per-slave accept.
REQ-012 s_cmd_wr/s_cmd_instr (1), s_cmd_addr/s_cmd_wdata (32), s_cmd_be (4)  outputs  broadcast copies of CPU command fields.
REQ-013 s_rsp_ready  input  NR_SLAVES  per-slave read-data valid; s_rsp_rdata  input  32*NR_SLAVES  flattened read data.

Function
REQ-014 Slave i SHALL be selected when (mem_cmd_addr & MASK_i) == BASE_i; lowest index wins on overlap; no match selects internal void target.
REQ-015 Command accepted (handshake) SHALL occur when mem_cmd_valid && mem_cmd_ready; s_cmd_valid[i] = mem_cmd_valid && sel_i && !stall.
REQ-016 mem_cmd_ready SHALL equal (selected slave s_cmd_ready, or 1 for void) && !stall; purely combinational, zero added latency on command path.
REQ-017 stall SHALL assert for a read when outstanding count == MAX_OUTSTANDING, even if a response pops the same cycle.
REQ-018 stall SHALL assert for a read whose target differs from the last-pushed target while outstanding count != 0 (in-order guarantee).
REQ-019 Writes SHALL never stall on outstanding reads, never push a tracking entry, and produce no response.
REQ-020 Each accepted read SHALL push its target ID (0..NR_SLAVES, NR_SLAVES = void) into an in-order tracking FIFO.
REQ-021 mem_rsp_ready/mem_rsp_rdata SHALL combinationally mux s_rsp_ready/s_rsp_rdata of the head target; head entry pops on that beat.
REQ-022 s_rsp_ready from a non-head slave, or with FIFO empty, SHALL be ignored.
REQ-023 Void read SHALL return mem_rsp_ready=1, mem_rsp_rdata=32'd0 exactly one cycle after accept, once it is at head.
REQ-024 mem_rsp_rdata SHALL be 32'd0 whenever mem_rsp_ready=0.
REQ-025 Simultaneous push and pop SHALL keep the count unchanged; pointers wrap modulo MAX_OUTSTANDING.

Reset
REQ-026 On reset: FIFO empty, count 0, void responder idle, mem_rsp_ready=0, all s_cmd_valid=0, err outputs 0.
REQ-027 Reset mid-transaction SHALL discard outstanding reads; late slave responses after reset SHALL be ignored (FIFO empty).

Configuration
REQ-028 Macro MEM_BUS_DECODER_ERR_EN defined: outputs err_valid (1, one-cycle pulse on accepted void access, read or write), err_addr (32, sticky address of first void access), err_wr (1), input err_clr (1) clears sticky capture.
REQ-029 Macro undefined: error ports absent; void accesses complete silently per REQ-019/REQ-023.

Structure
REQ-030 Shared package mem_bus_pkg SHALL hold bus width constants (32 addr/data, 4 be) and the target-ID width function.
REQ-031 Tracking FIFO SHALL be a sub-module mem_bus_rsp_fifo (parametrised depth/width, push/pop/full/empty/count).

Verification
REQ-032 Read 0x00000100 (slave 0, 2-cycle latency, rdata 0x12345678) -> mem_rsp_ready one cycle, rdata 0x12345678, count back to 0.
REQ-033 Four back-to-back reads to slave 1 without responses, fifth read -> mem_cmd_ready=0 until first s_rsp_ready[1].
REQ-034 Read slave 0 outstanding, then read slave 1 -> stalled until slave 0 responds; then accepted.
REQ-035 Read 0x80000000 -> mem_rsp_ready=1, rdata 0 next cycle; with ERR_EN err_valid pulse, err_addr=0x80000000, err_wr=0.
REQ-036 s_cmd_ready[2]=0 for 3 cycles on write 0x00010004 -> mem_cmd_ready=0 3 cycles, s_cmd_valid[2] held, single accept.
REQ-037 Reset asserted with 2 reads outstanding, slave responds afterwards -> mem_rsp_ready stays 0.

Source files
------------

// File: rtl/mem_bus_decoder_pkg.sv
// mem_bus_pkg: shared constants and helpers for the memory bus decoder.
//   ADDR_W / DATA_W / BE_W : CPU and slave bus field widths.
//   tid_width(n)           : bits needed for a target ID in 0..n, where ID n
//                            is the internal void target.
package mem_bus_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int BE_W   = 4;

  function automatic int tid_width(input int nr_slaves);
    int w;
    w = 1;
    while ((1 << w) < (nr_slaves + 1)) w = w + 1;
    return w;
  endfunction

endpackage

// File: rtl/mem_bus_decoder_if.sv
// mem_bus_decoder_if: CPU-side command/response bus of the decoder.
//   master modport : CPU (drives the command, receives ready and read data)
//   slave  modport : decoder (accepts the command, returns read data)
// Command handshake: a command transfers on a rising clk edge where
// mem_cmd_valid && mem_cmd_ready; the CPU holds all command fields stable
// while mem_cmd_valid is high and not yet accepted. mem_rsp_ready is a
// single-beat read-data strobe with no back-pressure.
interface mem_bus_decoder_if;
  import mem_bus_pkg::*;

  logic              mem_cmd_valid;
  logic              mem_cmd_wr;
  logic              mem_cmd_instr;
  logic [ADDR_W-1:0] mem_cmd_addr;
  logic [DATA_W-1:0] mem_cmd_wdata;
  logic [BE_W-1:0]   mem_cmd_be;
  logic              mem_cmd_ready;
  logic              mem_rsp_ready;
  logic [DATA_W-1:0] mem_rsp_rdata;

  modport master (
    output mem_cmd_valid, mem_cmd_wr, mem_cmd_instr, mem_cmd_addr,
           mem_cmd_wdata, mem_cmd_be,
    input  mem_cmd_ready, mem_rsp_ready, mem_rsp_rdata
  );

  modport slave (
    input  mem_cmd_valid, mem_cmd_wr, mem_cmd_instr, mem_cmd_addr,
           mem_cmd_wdata, mem_cmd_be,
    output mem_cmd_ready, mem_rsp_ready, mem_rsp_rdata
  );

endinterface

// File: rtl/mem_bus_decoder_rsp_fifo.sv
// mem_bus_rsp_fifo: in-order tracking FIFO of target IDs for accepted reads.
//   clk, reset        : clock, asynchronous active-high reset
//   push, push_data   : write an entry (ignored when full)
//   pop               : drop the head entry (ignored when empty)
//   head_data         : current head entry (meaningful only when !empty)
//   full, empty, count: occupancy status
// DEPTH must be a power of two so the pointers wrap by natural overflow.
module mem_bus_rsp_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 3
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push,
  input  logic [WIDTH-1:0]             push_data,
  input  logic                         pop,
  output logic [WIDTH-1:0]             head_data,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] cnt;
  logic             do_push;
  logic             do_pop;

  assign full    = (cnt == CNT_W'(DEPTH));
  assign empty   = (cnt == '0);
  assign count   = cnt;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head_data = mem[rd_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + CNT_W'(1);
        2'b01:   cnt <= cnt - CNT_W'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage needs no reset: an entry is only read after it was written.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/mem_bus_decoder.sv
// mem_bus_decoder: address decoder from one CPU port to NR_SLAVES slaves,
// with in-order read response tracking and an internal void target.
//   clk, reset        : clock, asynchronous active-high reset
//   cpu               : CPU command/response bus (mem_bus_decoder_if.slave)
//   s_cmd_*           : per-slave valid/ready, broadcast command fields
//   s_rsp_ready/rdata : per-slave read data strobe and flattened data
//   dbg_outstanding   : number of accepted reads awaiting a response
// Optional macro MEM_BUS_DECODER_ERR_EN adds err_valid/err_addr/err_wr
// outputs and the err_clr input for void-access reporting.
module mem_bus_decoder
  import mem_bus_pkg::*;
#(
  parameter int NR_SLAVES       = 4,
  parameter int MAX_OUTSTANDING = 4,
  parameter logic [32*NR_SLAVES-1:0] SLAVE_BASE =
    {32'hf0000000, 32'h00010000, 32'h00002000, 32'h00000000},
  parameter logic [32*NR_SLAVES-1:0] SLAVE_MASK =
    {32'hffff0000, 32'hffff0000, 32'hffffe000, 32'hffffe000}
) (
  input  logic                          clk,
  input  logic                          reset,
  mem_bus_decoder_if.slave              cpu,
  output logic [NR_SLAVES-1:0]          s_cmd_valid,
  input  logic [NR_SLAVES-1:0]          s_cmd_ready,
  output logic                          s_cmd_wr,
  output logic                          s_cmd_instr,
  output logic [ADDR_W-1:0]             s_cmd_addr,
  output logic [DATA_W-1:0]             s_cmd_wdata,
  output logic [BE_W-1:0]               s_cmd_be,
  input  logic [NR_SLAVES-1:0]          s_rsp_ready,
  input  logic [DATA_W*NR_SLAVES-1:0]   s_rsp_rdata,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0] dbg_outstanding
`ifdef MEM_BUS_DECODER_ERR_EN
  ,
  output logic                          err_valid,
  output logic [ADDR_W-1:0]             err_addr,
  output logic                          err_wr,
  input  logic                          err_clr
`endif
);

  localparam int TID_W = tid_width(NR_SLAVES);
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [TID_W-1:0] VOID_TID = TID_W'(NR_SLAVES);

  logic             hit;
  logic [TID_W-1:0] sel_idx;
  logic [TID_W-1:0] tgt;
  logic             sel_ready;
  logic             stall;
  logic             accept;
  logic             push;
  logic             pop;
  logic [TID_W-1:0] last_tid;
  logic [TID_W-1:0] head_tid;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CNT_W-1:0] fifo_count;
  logic             rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;

  // Descending scan so the lowest matching index is the last one written.
  always_comb begin
    hit     = 1'b0;
    sel_idx = '0;
    for (int i = NR_SLAVES - 1; i >= 0; i--) begin
      if ((cpu.mem_cmd_addr & SLAVE_MASK[i*32 +: 32]) == SLAVE_BASE[i*32 +: 32]) begin
        hit     = 1'b1;
        sel_idx = TID_W'(i);
      end
    end
  end

  assign tgt = hit ? sel_idx : VOID_TID;

  // A read stalls when tracking is full (a same-cycle pop does not help) or
  // when it would switch target while older reads are still in flight;
  // the latter keeps every FIFO entry on one target, so responses stay
  // in order without reordering logic.
  assign stall = cpu.mem_cmd_valid && !cpu.mem_cmd_wr &&
                 (fifo_full || (!fifo_empty && (tgt != last_tid)));

  always_comb begin
    sel_ready = !hit;
    for (int i = 0; i < NR_SLAVES; i++) begin
      if (hit && (sel_idx == TID_W'(i))) sel_ready = s_cmd_ready[i];
    end
  end

  always_comb begin
    s_cmd_valid = '0;
    for (int i = 0; i < NR_SLAVES; i++) begin
      if (hit && (sel_idx == TID_W'(i))) s_cmd_valid[i] = cpu.mem_cmd_valid && !stall;
    end
  end

  assign cpu.mem_cmd_ready = sel_ready && !stall;
  assign accept = cpu.mem_cmd_valid && cpu.mem_cmd_ready;
  assign push   = accept && !cpu.mem_cmd_wr;

  assign s_cmd_wr    = cpu.mem_cmd_wr;
  assign s_cmd_instr = cpu.mem_cmd_instr;
  assign s_cmd_addr  = cpu.mem_cmd_addr;
  assign s_cmd_wdata = cpu.mem_cmd_wdata;
  assign s_cmd_be    = cpu.mem_cmd_be;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) last_tid <= '0;
    else if (push) last_tid <= tgt;
  end

  mem_bus_rsp_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .WIDTH (TID_W)
  ) u_rsp_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (tgt),
    .pop       (pop),
    .head_data (head_tid),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // Void reads answer as soon as they reach the head: an entry is visible
  // one cycle after its push, which gives the one-cycle void latency.
  always_comb begin
    rsp_ready = 1'b0;
    rsp_rdata = '0;
    if (!fifo_empty) begin
      if (head_tid == VOID_TID) begin
        rsp_ready = 1'b1;
      end else begin
        for (int i = 0; i < NR_SLAVES; i++) begin
          if (head_tid == TID_W'(i)) begin
            rsp_ready = s_rsp_ready[i];
            rsp_rdata = s_rsp_rdata[i*DATA_W +: DATA_W];
          end
        end
      end
    end
    if (!rsp_ready) rsp_rdata = '0;
  end

  assign pop               = rsp_ready;
  assign cpu.mem_rsp_ready = rsp_ready;
  assign cpu.mem_rsp_rdata = rsp_rdata;
  assign dbg_outstanding   = fifo_count;

`ifdef MEM_BUS_DECODER_ERR_EN
  logic err_held;

  // err_addr/err_wr hold the first void access until err_clr.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_valid <= 1'b0;
      err_addr  <= '0;
      err_wr    <= 1'b0;
      err_held  <= 1'b0;
    end else begin
      err_valid <= accept && !hit;
      if (err_clr) begin
        err_held <= 1'b0;
        err_addr <= '0;
        err_wr   <= 1'b0;
      end else if (accept && !hit && !err_held) begin
        err_held <= 1'b1;
        err_addr <= cpu.mem_cmd_addr;
        err_wr   <= cpu.mem_cmd_wr;
      end
    end
  end
`endif

endmodule

// File: tb/tb_mem_bus_decoder.sv
// tb_mem_bus_decoder: directed bench for mem_bus_decoder (default parameters).
module tb_mem_bus_decoder;

  localparam int NS = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mem_bus_decoder_if cpu_if();

  logic [NS-1:0]    s_cmd_valid;
  logic [NS-1:0]    s_cmd_ready;
  logic             s_cmd_wr;
  logic             s_cmd_instr;
  logic [31:0]      s_cmd_addr;
  logic [31:0]      s_cmd_wdata;
  logic [3:0]       s_cmd_be;
  logic [NS-1:0]    s_rsp_ready;
  logic [32*NS-1:0] s_rsp_rdata;
  logic [2:0]       dbg_outstanding;
`ifdef MEM_BUS_DECODER_ERR_EN
  logic             err_valid;
  logic [31:0]      err_addr;
  logic             err_wr;
  logic             err_clr;
`endif

  int checks = 0;
  int errors = 0;
  int acc_cnt = 0;
  int acc_base;

  mem_bus_decoder dut (
    .clk             (clk),
    .reset           (reset),
    .cpu             (cpu_if),
    .s_cmd_valid     (s_cmd_valid),
    .s_cmd_ready     (s_cmd_ready),
    .s_cmd_wr        (s_cmd_wr),
    .s_cmd_instr     (s_cmd_instr),
    .s_cmd_addr      (s_cmd_addr),
    .s_cmd_wdata     (s_cmd_wdata),
    .s_cmd_be        (s_cmd_be),
    .s_rsp_ready     (s_rsp_ready),
    .s_rsp_rdata     (s_rsp_rdata),
    .dbg_outstanding (dbg_outstanding)
`ifdef MEM_BUS_DECODER_ERR_EN
    ,
    .err_valid       (err_valid),
    .err_addr        (err_addr),
    .err_wr          (err_wr),
    .err_clr         (err_clr)
`endif
  );

  // Command handshakes observed on the active edge.
  always @(posedge clk) begin
    if (cpu_if.mem_cmd_valid && cpu_if.mem_cmd_ready) acc_cnt <= acc_cnt + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic drive_cmd(input logic v, input logic wr, input logic ins,
                           input logic [31:0] a, input logic [31:0] wd, input logic [3:0] be);
    cpu_if.mem_cmd_valid = v;
    cpu_if.mem_cmd_wr    = wr;
    cpu_if.mem_cmd_instr = ins;
    cpu_if.mem_cmd_addr  = a;
    cpu_if.mem_cmd_wdata = wd;
    cpu_if.mem_cmd_be    = be;
  endtask

  task automatic cmd_idle();
    drive_cmd(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
  endtask

  task automatic slave_rsp(input int idx, input logic [31:0] data);
    s_rsp_ready = '0;
    s_rsp_ready[idx] = 1'b1;
    s_rsp_rdata[idx*32 +: 32] = data;
  endtask

  task automatic rsp_idle();
    s_rsp_ready = '0;
  endtask

  initial begin
    reset = 1'b1;
    cmd_idle();
    s_cmd_ready = '1;
    s_rsp_ready = '0;
    s_rsp_rdata = '0;
`ifdef MEM_BUS_DECODER_ERR_EN
    err_clr = 1'b0;
`endif

    // Reset state
    tick();
    tick();
    check("reset_count", 32'(dbg_outstanding), 32'd0);
    check("reset_rsp_ready", 32'(cpu_if.mem_rsp_ready), 32'd0);
    check("reset_rsp_rdata", cpu_if.mem_rsp_rdata, 32'd0);
    check("reset_s_cmd_valid", 32'(s_cmd_valid), 32'd0);
`ifdef MEM_BUS_DECODER_ERR_EN
    check("reset_err_valid", 32'(err_valid), 32'd0);
    check("reset_err_addr", err_addr, 32'd0);
`endif
    reset = 1'b0;
    tick();

    // Read slave 0 with two-cycle latency
    drive_cmd(1'b1, 1'b0, 1'b0, 32'h0000_0100, 32'h0, 4'hf);
    settle();
    check("rd0_s_cmd_valid", 32'(s_cmd_valid), 32'h1);
    check("rd0_cmd_ready", 32'(cpu_if.mem_cmd_ready), 32'd1);
    tick();
    cmd_idle();
    settle();
    check("rd0_count_1", 32'(dbg_outstanding), 32'd1);
    check("rd0_no_rsp_yet", 32'(cpu_if.mem_rsp_ready), 32'd0);
    tick();
    slave_rsp(0, 32'h1234_5678);
    settle();
    check("rd0_rsp_ready", 32'(cpu_if.mem_rsp_ready), 32'd1);
    check("rd0_rsp_rdata", cpu_if.mem_rsp_rdata, 32'h1234_5678);
    tick();
    rsp_idle();
    settle();
    check("rd0_count_0", 32'(dbg_outstanding), 32'd0);
    check("rd0_rsp_done", 32'(cpu_if.mem_rsp_ready), 32'd0);
    check("rd0_rdata_zero", cpu_if.mem_rsp_rdata, 32'd0);

    // Response with empty tracking FIFO is ignored
    slave_rsp(1, 32'haaaa_5555);
    settle();
    check("empty_rsp_ready", 32'(cpu_if.mem_rsp_ready), 32'd0);
    check("empty_rsp_rdata", cpu_if.mem_rsp_rdata, 32'd0);
    tick();
    rsp_idle();
    settle();
    check("empty_rsp_count", 32'(dbg_outstanding), 32'd0);

    // Fill to MAX_OUTSTANDING on slave 1, fifth read waits
    drive_cmd(1'b1, 1'b0, 1'b0, 32'h0000_2000, 32'h0, 4'hf);
    settle();
    check("fill_s_cmd_valid", 32'(s_cmd_valid), 32'h2);
    for (int k = 1; k <= 4; k++) begin
      tick();
      check($sformatf("fill_count_%0d", k), 32'(dbg_outstanding), 32'(k));
    end
    check("full_cmd_ready", 32'(cpu_if.mem_cmd_ready), 32'd0);
    check("full_s_cmd_valid", 32'(s_cmd_valid), 32'd0);
    tick();
    check("full_hold_count", 32'(dbg_outstanding), 32'd4);
    check("full_hold_ready", 32'(cpu_if.mem_cmd_ready), 32'd0);
    slave_rsp(1, 32'h1111_0001);
    settle();
    check("full_pop_rsp", 32'(cpu_if.mem_rsp_ready), 32'd1);
    check("full_pop_rdata", cpu_if.mem_rsp_rdata, 32'h1111_0001);
    check("full_pop_still_stall", 32'(cpu_if.mem_cmd_ready), 32'd0);
    tick();
    rsp_idle();
    settle();
    check("after_pop_count", 32'(dbg_outstanding), 32'd3);
    check("after_pop_ready", 32'(cpu_if.mem_cmd_ready), 32'd1);
    tick();
    cmd_idle();
    settle();
    check("fifth_count", 32'(dbg_outstanding), 32'd4);
    for (int k = 0; k < 4; k++) begin
      slave_rsp(1, 32'h1111_0010 + 32'(k));
      settle();
      check($sformatf("drain_rsp_%0d", k), 32'(cpu_if.mem_rsp_ready), 32'd1);
      check($sformatf("drain_rdata_%0d", k), cpu_if.mem_rsp_rdata, 32'h1111_0010 + 32'(k));
      tick();
    end
    rsp_idle();
    settle();
    check("drain_count", 32'(dbg_outstanding), 32'd0);

    // Target switch waits for older reads
    drive_cmd(1'b1, 1'b0, 1'b0, 32'h0000_0100, 32'h0, 4'hf);
    tick();
    drive_cmd(1'b1, 1'b0, 1'b1, 32'h0000_2004, 32'h0, 4'hf);
    slave_rsp(1, 32'h7777_7777);
    settle();
    check("switch_stall_ready", 32'(cpu_if.mem_cmd_ready), 32'd0);
    check("switch_stall_valid", 32'(s_cmd_valid), 32'd0);
    check("nonhead_rsp_ready", 32'(cpu_if.mem_rsp_ready), 32'd0);
    check("nonhead_rsp_rdata", cpu_if.mem_rsp_rdata, 32'd0);
    tick();
    rsp_idle();
    settle();
    check("switch_count_1", 32'(dbg_outstanding), 32'd1);
    slave_rsp(0, 32'hcafe_0000);
    settle();
    check("switch_head_rsp", 32'(cpu_if.mem_rsp_ready), 32'd1);
    check("switch_head_rdata", cpu_if.mem_rsp_rdata, 32'hcafe_0000);
    check("switch_pop_stall", 32'(cpu_if.mem_cmd_ready), 32'd0);
    tick();
    rsp_idle();
    settle();
    check("switch_accept_ready", 32'(cpu_if.mem_cmd_ready), 32'd1);
    check("switch_accept_valid", 32'(s_cmd_valid), 32'h2);
    check("switch_instr", 32'(s_cmd_instr), 32'd1);
    tick();
    cmd_idle();
    settle();
    check("switch_count_after", 32'(dbg_outstanding), 32'd1);
    slave_rsp(1, 32'h0bee_f001);
    settle();
    check("switch_s1_rdata", cpu_if.mem_rsp_rdata, 32'h0bee_f001);
    tick();
    rsp_idle();
    settle();
    check("switch_count_0", 32'(dbg_outstanding), 32'd0);

    // Void read
    drive_cmd(1'b1, 1'b0, 1'b0, 32'h8000_0000, 32'h0, 4'hf);
    settle();
    check("void_cmd_ready", 32'(cpu_if.mem_cmd_ready), 32'd1);
    check("void_s_cmd_valid", 32'(s_cmd_valid), 32'd0);
    tick();
    cmd_idle();
    settle();
    check("void_rsp_ready", 32'(cpu_if.mem_rsp_ready), 32'd1);
    check("void_rsp_rdata", cpu_if.mem_rsp_rdata, 32'd0);
    check("void_count", 32'(dbg_outstanding), 32'd1);
`ifdef MEM_BUS_DECODER_ERR_EN
    check("void_err_valid", 32'(err_valid), 32'd1);
    check("void_err_addr", err_addr, 32'h8000_0000);
    check("void_err_wr", 32'(err_wr), 32'd0);
`endif
    tick();
    check("void_rsp_done", 32'(cpu_if.mem_rsp_ready), 32'd0);
    check("void_count_0", 32'(dbg_outstanding), 32'd0);
`ifdef MEM_BUS_DECODER_ERR_EN
    check("void_err_pulse_end", 32'(err_valid), 32'd0);
`endif

    // Write does not stall behind an outstanding read to another slave
    drive_cmd(1'b1, 1'b0, 1'b0, 32'h0000_2000, 32'h0, 4'hf);
    tick();
    drive_cmd(1'b1, 1'b1, 1'b0, 32'h0000_0100, 32'ha5a5_a5a5, 4'b0110);
    settle();
    check("wr_nostall_ready", 32'(cpu_if.mem_cmd_ready), 32'd1);
    check("wr_nostall_valid", 32'(s_cmd_valid), 32'h1);
    check("wr_bcast_wr", 32'(s_cmd_wr), 32'd1);
    check("wr_bcast_wdata", s_cmd_wdata, 32'ha5a5_a5a5);
    check("wr_bcast_be", 32'(s_cmd_be), 32'h6);
    tick();
    cmd_idle();
    settle();
    check("wr_no_push", 32'(dbg_outstanding), 32'd1);
    slave_rsp(1, 32'h1357_2468);
    settle();
    check("wr_read_rdata", cpu_if.mem_rsp_rdata, 32'h1357_2468);
    tick();
    rsp_idle();
    settle();
    check("wr_read_count_0", 32'(dbg_outstanding), 32'd0);

    // Void write completes silently
    drive_cmd(1'b1, 1'b1, 1'b0, 32'h8000_0000, 32'h1, 4'hf);
    settle();
    check("void_wr_ready", 32'(cpu_if.mem_cmd_ready), 32'd1);
    tick();
    cmd_idle();
    settle();
    check("void_wr_no_rsp", 32'(cpu_if.mem_rsp_ready), 32'd0);
    check("void_wr_count", 32'(dbg_outstanding), 32'd0);
`ifdef MEM_BUS_DECODER_ERR_EN
    check("void_wr_err_valid", 32'(err_valid), 32'd1);
    check("void_wr_err_sticky", err_addr, 32'h8000_0000);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    settle();
    check("err_clr_addr", err_addr, 32'd0);
`endif

    // Slave 2 back-pressure on a write
    s_cmd_ready = 4'b1011;
    acc_base = acc_cnt;
    drive_cmd(1'b1, 1'b1, 1'b1, 32'h0001_0004, 32'h0f0f_0f0f, 4'hf);
    for (int k = 0; k < 3; k++) begin
      settle();
      check($sformatf("bp_ready_%0d", k), 32'(cpu_if.mem_cmd_ready), 32'd0);
      check($sformatf("bp_valid_%0d", k), 32'(s_cmd_valid), 32'h4);
      tick();
    end
    s_cmd_ready = 4'hf;
    settle();
    check("bp_release_ready", 32'(cpu_if.mem_cmd_ready), 32'd1);
    check("bp_addr", s_cmd_addr, 32'h0001_0004);
    check("bp_instr", 32'(s_cmd_instr), 32'd1);
    tick();
    cmd_idle();
    settle();
    check("bp_single_accept", 32'(acc_cnt - acc_base), 32'd1);
    check("bp_valid_drop", 32'(s_cmd_valid), 32'd0);

    // Reset with two reads outstanding, late response ignored
    drive_cmd(1'b1, 1'b0, 1'b0, 32'h0000_0100, 32'h0, 4'hf);
    tick();
    tick();
    cmd_idle();
    settle();
    check("rst_pre_count", 32'(dbg_outstanding), 32'd2);
    reset = 1'b1;
    settle();
    check("rst_async_count", 32'(dbg_outstanding), 32'd0);
    tick();
    reset = 1'b0;
    tick();
    slave_rsp(0, 32'h0000_0055);
    settle();
    check("rst_late_rsp", 32'(cpu_if.mem_rsp_ready), 32'd0);
    check("rst_late_rdata", cpu_if.mem_rsp_rdata, 32'd0);
    tick();
    rsp_idle();
    settle();
    check("rst_late_count", 32'(dbg_outstanding), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
